mem_port_arbiter: RTL and testbench

- Shares the single data port of the RAM module between two requesters:
  - CPU load/store path (read/write).
  - GPU/video fetch path (read-only).
- Sits between the processor/chipset data path and the RAM.
- Arbitration is burst-limited with a pipelined request/grant handshake, one access per cycle.
- Read data returns to the originating requester with a tagged fixed-latency valid pulse.

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single RAM data port between the CPU load/store path
//             (read/write) and the GPU/video fetch path (read-only). Grants
//             are combinational on registered state, one access per cycle,
//             with a burst limit so a continuously requesting owner cannot
//             starve the other side. The RAM command is registered. Read data
//             returns through a tag pipeline aligned to the RAM read latency.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             cpu_req/we/addr/wdata, cpu_gnt - CPU request side
//             cpu_rvalid, cpu_rdata          - CPU read return
//             gpu_req/addr, gpu_gnt          - GPU request side (reads only)
//             gpu_rvalid, gpu_rdata          - GPU read return
//             mem_en/we/addr/wdata, mem_rdata - RAM port
//             busy                           - command issued or read in flight
//  Options  : `define ARB_PERF_EN adds perf_clr input and 16-bit saturating
//             cpu_wait_cnt / gpu_wait_cnt outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          gpu_req,
    input  logic [AW-1:0] gpu_addr,
    output logic          gpu_gnt,
    output logic          gpu_rvalid,
    output logic [DW-1:0] gpu_rdata,
`ifdef ARB_PERF_EN
    input  logic          perf_clr,
    output logic [15:0]   cpu_wait_cnt,
    output logic [15:0]   gpu_wait_cnt,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_GPU  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    owner_t          owner_q, owner_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic            cpu_win, gpu_win;
    logic            burst_full;
    logic [3:0]      bcnt_inc;

    logic            mem_en_q, mem_we_q, mem_gpu_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_gpu_q, tag_gpu_d;
    logic [RD_LAT:0]   tag_vld_sh, tag_gpu_sh;

    assign burst_full = (bcnt_q == MAX_BURST_C);
    assign bcnt_inc   = burst_full ? bcnt_q : bcnt_q + 4'd1;

    // Grant decision and owner/burst-counter next state.
    always_comb begin
        cpu_win = 1'b0;
        gpu_win = 1'b0;
        owner_d = OWN_IDLE;
        bcnt_d  = 4'd0;
        if (!rst) begin
            case (owner_q)
                OWN_CPU: begin
                    if (cpu_req) begin
                        if (burst_full && gpu_req) gpu_win = 1'b1;
                        else                       cpu_win = 1'b1;
                    end else begin
                        gpu_win = gpu_req;
                    end
                end
                OWN_GPU: begin
                    if (gpu_req) begin
                        if (burst_full && cpu_req) cpu_win = 1'b1;
                        else                       gpu_win = 1'b1;
                    end else begin
                        cpu_win = cpu_req;
                    end
                end
                default: begin
                    // From idle the CPU wins a tie.
                    cpu_win = cpu_req;
                    gpu_win = gpu_req & ~cpu_req;
                end
            endcase
        end
        if (cpu_win) begin
            owner_d = OWN_CPU;
            bcnt_d  = (owner_q == OWN_CPU) ? bcnt_inc : 4'd1;
        end else if (gpu_win) begin
            owner_d = OWN_GPU;
            bcnt_d  = (owner_q == OWN_GPU) ? bcnt_inc : 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
            bcnt_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Registered RAM command; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_gpu_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= cpu_win | gpu_win;
            if (cpu_win) begin
                mem_we_q    <= cpu_we;
                mem_gpu_q   <= 1'b0;
                mem_addr_q  <= cpu_addr;
                mem_wdata_q <= cpu_wdata;
            end else if (gpu_win) begin
                mem_we_q    <= 1'b0;
                mem_gpu_q   <= 1'b1;
                mem_addr_q  <= gpu_addr;
            end
        end
    end

    // Read tag pipeline: a tag enters when a read command is on the RAM port
    // and leaves RD_LAT cycles later, in step with mem_rdata.
    assign tag_vld_sh = {tag_vld_q, mem_en_q & ~mem_we_q};
    assign tag_gpu_sh = {tag_gpu_q, mem_gpu_q};
    assign tag_vld_d  = tag_vld_sh[RD_LAT-1:0];
    assign tag_gpu_d  = tag_gpu_sh[RD_LAT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_gpu_q <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_gpu_q <= tag_gpu_d;
        end
    end

`ifdef ARB_PERF_EN
    logic [15:0] cpu_wait_q, gpu_wait_q;

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            cpu_wait_q <= 16'd0;
            gpu_wait_q <= 16'd0;
        end else begin
            if (cpu_req && !cpu_gnt && cpu_wait_q != 16'hFFFF)
                cpu_wait_q <= cpu_wait_q + 16'd1;
            if (gpu_req && !gpu_gnt && gpu_wait_q != 16'hFFFF)
                gpu_wait_q <= gpu_wait_q + 16'd1;
        end
    end

    assign cpu_wait_cnt = cpu_wait_q;
    assign gpu_wait_cnt = gpu_wait_q;
`endif

    assign cpu_gnt    = cpu_win;
    assign gpu_gnt    = gpu_win;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rvalid = tag_vld_q[RD_LAT-1] & ~tag_gpu_q[RD_LAT-1];
    assign gpu_rvalid = tag_vld_q[RD_LAT-1] &  tag_gpu_q[RD_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign gpu_rdata  = mem_rdata;
    assign busy       = mem_en_q | (|tag_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench. Two arbiters share one stimulus
//             stream: u_dut1 with RD_LAT=1 and u_dut3 with RD_LAT=3, each with
//             its own small RAM model. Expected values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, gpu_req;
    logic [31:0] cpu_addr, cpu_wdata, gpu_addr;

    logic        c_gnt1, c_rv1, g_gnt1, g_rv1, m_en1, m_we1, busy1;
    logic [31:0] c_rd1, g_rd1, m_addr1, m_wd1, m_rd1;
    logic        c_gnt3, c_rv3, g_gnt3, g_rv3, m_en3, m_we3, busy3;
    logic [31:0] c_rd3, g_rd3, m_addr3, m_wd3, m_rd3;
`ifdef ARB_PERF_EN
    logic        perf_clr;
    logic [15:0] cwc1, gwc1, cwc3, gwc3;
    initial perf_clr = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_BURST(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(c_gnt1), .cpu_rvalid(c_rv1), .cpu_rdata(c_rd1),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr),
        .gpu_gnt(g_gnt1), .gpu_rvalid(g_rv1), .gpu_rdata(g_rd1),
`ifdef ARB_PERF_EN
        .perf_clr(perf_clr), .cpu_wait_cnt(cwc1), .gpu_wait_cnt(gwc1),
`endif
        .mem_en(m_en1), .mem_we(m_we1), .mem_addr(m_addr1), .mem_wdata(m_wd1),
        .mem_rdata(m_rd1), .busy(busy1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_BURST(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(c_gnt3), .cpu_rvalid(c_rv3), .cpu_rdata(c_rd3),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr),
        .gpu_gnt(g_gnt3), .gpu_rvalid(g_rv3), .gpu_rdata(g_rd3),
`ifdef ARB_PERF_EN
        .perf_clr(perf_clr), .cpu_wait_cnt(cwc3), .gpu_wait_cnt(gwc3),
`endif
        .mem_en(m_en3), .mem_we(m_we3), .mem_addr(m_addr3), .mem_wdata(m_wd3),
        .mem_rdata(m_rd3), .busy(busy3)
    );

    // RAM models, indexed by the low address byte.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p0, p1, p2;

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem1[k] = 32'hC0DE_0000 + k;
            mem3[k] = 32'hC0DE_0000 + k;
        end
        mem1[8'h10] = 32'hDEADBEEF;
        mem3[8'h10] = 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (m_en1 && m_we1) mem1[m_addr1[7:0]] <= m_wd1;
        m_rd1 <= mem1[m_addr1[7:0]];
        if (m_en3 && m_we3) mem3[m_addr3[7:0]] <= m_wd3;
        p0 <= mem3[m_addr3[7:0]];
        p1 <= p0;
        p2 <= p1;
    end
    assign m_rd3 = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    bit [5:0] seq_cpu;

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        gpu_req = 1'b1; gpu_addr = '0;
        seq_cpu = 6'b101111;

        // Reset: no grants even with requests, command and pipeline cleared.
        step(); settle();
        check_val("rst_cpu_gnt1", c_gnt1, 0);
        check_val("rst_gpu_gnt1", g_gnt1, 0);
        check_val("rst_cpu_gnt3", c_gnt3, 0);
        check_val("rst_mem_en1", m_en1, 0);
        check_val("rst_mem_addr1", m_addr1, 0);
        check_val("rst_busy1", busy1, 0);
        cpu_req = 1'b0; gpu_req = 1'b0;
        step(); rst = 1'b0;
        step();

        // Single CPU read of 0x10 (RD_LAT=1).
        cpu_req = 1'b1; cpu_addr = 32'h10; settle();
        check_val("t1_cpu_gnt", c_gnt1, 1);
        check_val("t1_gpu_gnt", g_gnt1, 0);
        step(); cpu_req = 1'b0; settle();
        check_val("t1_mem_en", m_en1, 1);
        check_val("t1_mem_addr", m_addr1, 32'h10);
        check_val("t1_mem_we", m_we1, 0);
        check_val("t1_busy", busy1, 1);
        step(); settle();
        check_val("t1_cpu_rvalid", c_rv1, 1);
        check_val("t1_cpu_rdata", c_rd1, 32'hDEADBEEF);
        check_val("t1_gpu_rvalid", g_rv1, 0);
        step(); settle();
        check_val("t1_rvalid_pulse", c_rv1, 0);
        check_val("t1_busy_end", busy1, 0);

        // Tie from idle, then burst limit: C C C C G C.
        cpu_req = 1'b1; gpu_req = 1'b1; cpu_addr = 32'h11; gpu_addr = 32'h12;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_val($sformatf("t2_cpu_gnt%0d", i), c_gnt1, seq_cpu[i]);
            check_val($sformatf("t2_gpu_gnt%0d", i), g_gnt1, !seq_cpu[i]);
            step();
            if (i == 4) gpu_req = 1'b0;
            if (i == 5) cpu_req = 1'b0;
        end
        repeat (6) step();

        // CPU write 0x20, then read it back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; settle();
        check_val("t3_wr_gnt", c_gnt1, 1);
        step(); cpu_req = 1'b0; cpu_we = 1'b0; settle();
        check_val("t3_mem_en", m_en1, 1);
        check_val("t3_mem_we", m_we1, 1);
        check_val("t3_mem_addr", m_addr1, 32'h20);
        check_val("t3_mem_wdata", m_wd1, 32'h12345678);
        step(); cpu_req = 1'b1; cpu_addr = 32'h20; settle();
        check_val("t3_no_wr_rvalid", c_rv1, 0);
        check_val("t3_rd_gnt", c_gnt1, 1);
        step(); cpu_req = 1'b0; settle();
        check_val("t3_rd_mem_we", m_we1, 0);
        step(); settle();
        check_val("t3_rd_rvalid", c_rv1, 1);
        check_val("t3_rd_rdata", c_rd1, 32'h12345678);
        repeat (6) step();

        // GPU streams 8 reads with CPU idle.
        for (int i = 0; i < 10; i++) begin
            gpu_req = (i < 8); gpu_addr = 32'h4000 + i; settle();
            if (i < 8) check_val($sformatf("t4_gpu_gnt%0d", i), g_gnt1, 1);
            check_val($sformatf("t4_cpu_gnt%0d", i), c_gnt1, 0);
            check_val($sformatf("t4_mem_en%0d", i), m_en1, (i >= 1 && i <= 8));
            if (i >= 1 && i <= 8)
                check_val($sformatf("t4_mem_addr%0d", i), m_addr1, 32'h4000 + i - 1);
            check_val($sformatf("t4_gpu_rvalid%0d", i), g_rv1, (i >= 2 && i <= 9));
            if (i >= 2)
                check_val($sformatf("t4_gpu_rdata%0d", i), g_rd1, 32'hC0DE_0000 + i - 2);
            step();
        end
        gpu_req = 1'b0;
        repeat (6) step();

        // Alternating CPU/GPU reads on the RD_LAT=3 instance.
        for (int i = 0; i < 9; i++) begin
            cpu_req = (i < 4) && (i % 2 == 0);
            gpu_req = (i < 4) && (i % 2 == 1);
            cpu_addr = 32'(i + 1); gpu_addr = 32'(i + 1); settle();
            if (i < 4) begin
                check_val($sformatf("t5_cpu_gnt%0d", i), c_gnt3, (i % 2 == 0));
                check_val($sformatf("t5_gpu_gnt%0d", i), g_gnt3, (i % 2 == 1));
            end
            check_val($sformatf("t5_cpu_rvalid%0d", i), c_rv3, (i == 4 || i == 6));
            check_val($sformatf("t5_gpu_rvalid%0d", i), g_rv3, (i == 5 || i == 7));
            if (i >= 4 && i <= 7)
                check_val($sformatf("t5_rdata%0d", i), c_rd3, 32'hC0DE_0000 + i - 3);
            if (i == 7) check_val("t5_busy_last", busy3, 1);
            if (i == 8) check_val("t5_busy_off", busy3, 0);
            step();
        end
        repeat (6) step();

        // Reset with two reads in flight on the RD_LAT=3 instance.
        cpu_req = 1'b1; cpu_addr = 32'h5; settle();
        check_val("t6_gnt_a", c_gnt3, 1);
        step(); cpu_req = 1'b0; gpu_req = 1'b1; gpu_addr = 32'h6; settle();
        check_val("t6_gnt_b", g_gnt3, 1);
        step(); rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h7; gpu_addr = 32'h8; settle();
        check_val("t6_rst_cpu_gnt", c_gnt3, 0);
        check_val("t6_rst_gpu_gnt", g_gnt3, 0);
        step(); rst = 1'b0; settle();
        check_val("t6_post_cpu_gnt", c_gnt3, 1);
        check_val("t6_post_gpu_gnt", g_gnt3, 0);
        check_val("t6_post_mem_en", m_en3, 0);
        check_val("t6_post_mem_addr", m_addr3, 0);
        check_val("t6_post_busy", busy3, 0);
        check_val("t6_post_rvalid", c_rv3 | g_rv3, 0);
        step(); cpu_req = 1'b0; settle();
        check_val("t6_gpu_gnt", g_gnt3, 1);
        check_val("t6_c4_rvalid", c_rv3 | g_rv3, 0);
        step(); gpu_req = 1'b0;
        for (int i = 5; i < 10; i++) begin
            settle();
            check_val($sformatf("t6_cpu_rvalid%0d", i), c_rv3, (i == 7));
            check_val($sformatf("t6_gpu_rvalid%0d", i), g_rv3, (i == 8));
            if (i == 7) check_val("t6_cpu_rdata", c_rd3, 32'hC0DE_0007);
            if (i == 8) check_val("t6_gpu_rdata", g_rd3, 32'hC0DE_0008);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
